// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store alignment stage.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] EXT_LB  = 2'd0;
  localparam logic [1:0] EXT_LBU = 2'd1;
  localparam logic [1:0] EXT_LH  = 2'd2;
  localparam logic [1:0] EXT_LHU = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_mem_align_if.sv
// lsu_mem_align_if: request, data-memory and response signals of the alignment stage.
interface lsu_mem_align_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_ext_sel;
  logic              resp_is_word;
  logic              resp_err;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata, dm_ack,
    input  req_ready, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  resp_valid, resp_rdata, resp_ext_sel, resp_is_word, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata, dm_ack,
    output req_ready, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output resp_valid, resp_rdata, resp_ext_sel, resp_is_word, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian byte-lane enables, store replication and load right-alignment.
module lsu_lane_align import lsu_pkg::*; (
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  output logic [3:0]  be,
  output logic [31:0] wr_rep,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_align
);
  // Reserved size 3 falls into the word case through the >= compare.
  always_comb begin
    be       = wr_size >= SZ_WORD ? 4'hf : wr_size == SZ_HALF ? (wr_off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << wr_off;
    wr_rep   = wr_size >= SZ_WORD ? wr_data : wr_size == SZ_HALF ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
    rd_align = rd_size >= SZ_WORD ? rd_data
             : rd_size == SZ_HALF ? {16'h0, rd_off[1] ? rd_data[31:16] : rd_data[15:0]}
             : {24'h0, 8'(rd_data >> {rd_off, 3'b000})};
  end
endmodule

// File: rtl/lsu_mem_align.sv
// lsu_mem_align: load/store access stage to a multi-cycle data memory with ack timeout.
// Optional LSU_MISALIGN_EXC_EN: misaligned half/word accesses skip memory and respond with error.
module lsu_mem_align import lsu_pkg::*; #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_mem_align_if.slave bus
);
  state_t            state;
  logic [7:0]        cnt;
  logic              we, mis, word_q, err_q;
  logic [1:0]        size, off, ext_q;
  logic [3:0]        be_n, be_q;
  logic [31:0]       wdata_n, rdata_al, wdata_q, rdata_q;
  logic [ADDR_W-1:0] addr_q;
  lsu_lane_align u_lane (
    .wr_size (bus.req_size),
    .wr_off  (bus.req_addr[1:0]),
    .wr_data (bus.req_wdata),
    .be      (be_n),
    .wr_rep  (wdata_n),
    .rd_size (size),
    .rd_off  (off),
    .rd_data (bus.dm_rdata),
    .rd_align(rdata_al)
  );
`ifdef LSU_MISALIGN_EXC_EN
  assign mis = (bus.req_size == SZ_HALF && bus.req_addr[0]) || (bus.req_size >= SZ_WORD && bus.req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign bus.req_ready    = state == IDLE;
  assign bus.dm_req       = state == WAIT;
  assign bus.dm_we        = we;
  assign bus.dm_be        = be_q;
  assign bus.dm_addr      = addr_q;
  assign bus.dm_wdata     = wdata_q;
  assign bus.resp_valid   = state == RESP;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_ext_sel = ext_q;
  assign bus.resp_is_word = word_q;
  assign bus.resp_err     = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we      <= 1'b0;
      size    <= '0;
      off     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ext_q   <= '0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req_valid) begin
            we      <= bus.req_we;
            size    <= bus.req_size;
            off     <= bus.req_addr[1:0];
            addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wdata_n;
            rdata_q <= '0;
            err_q   <= mis;
            ext_q   <= bus.req_we ? EXT_LB : {bus.req_size == SZ_HALF, bus.req_unsigned};
            word_q  <= !bus.req_we && bus.req_size >= SZ_WORD;
            state   <= mis ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (bus.dm_ack) begin
            rdata_q <= we ? '0 : rdata_al;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/lsu_mem_align.md
Name: lsu_mem_align

Overview:
- Load/store access stage between the execute stage and the multi-cycle data memory.
- Accepts one request at a time and generates the word-aligned address, byte enables and lane-replicated store data.
- Waits a variable number of cycles for memory acknowledge.
- For loads, right-aligns the selected byte/halfword and hands it with an extension select code to the downstream load-extension stage (codes 0 lb, 1 lbu, 2 lh, 3 lhu).

Parameters:
- TIMEOUT, 16: cycles in WAIT without dm_ack before the access is aborted with an error; legal range 2..255.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  block can accept a request (state IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word; 3 is reserved and treated as word.
- req_unsigned  in  1  load zero-extends (lbu/lhu).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- dm_req  out  1  memory access strobe, held until dm_ack.
- dm_we  out  1  memory write.
- dm_be  out  4  byte enables; bit i covers byte lane i (little-endian).
- dm_addr  out  ADDR_W  word address; bits [1:0] = 0.
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read word; valid when dm_ack = 1.
- dm_ack  in  1  access complete.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data: byte in [7:0] or half in [15:0] (upper bits 0), or full word; 0 for stores.
- resp_ext_sel  out  2  extension code for the downstream extension stage.
- resp_is_word  out  1  word load; downstream bypasses extension.
- resp_err  out  1  timeout (or misalignment, see Optional Feature); qualified by resp_valid.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, timeout counter 0, all captured registers 0.
  - Reset outputs: req_ready 1; dm_req, dm_we, resp_valid, resp_err, resp_is_word 0; dm_be 0; dm_addr, dm_wdata, resp_rdata 0; resp_ext_sel 0.
  - Reset mid-access drops dm_req immediately; the pending access is discarded with no response.
- States:
  - IDLE: req_ready = 1. req_valid = 1 captures all req_* fields and moves to WAIT.
  - WAIT: dm_req = 1 and all dm_* outputs come from registers (stable for the whole state).
    - dm_ack = 1: capture dm_rdata, go to RESP.
    - Otherwise increment the counter; when it reaches TIMEOUT-1 without ack, go to RESP with error.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. Counter is cleared on entry to IDLE.
- Latency: accept at cycle 0. With dm_ack in the first WAIT cycle (cycle 1), resp_valid is at cycle 2. Throughput is one access per 3 cycles minimum.
- Lanes (little-endian), with off = addr[1:0]:
  - byte: dm_be = 1<<off; dm_wdata = {4{wdata[7:0]}}; resp_rdata = rdata >> (8*off), masked to 8 bits.
  - half: dm_be = addr[1] ? 4'b1100 : 4'b0011; dm_wdata = {2{wdata[15:0]}}; resp_rdata = rdata half selected by addr[1].
  - word: dm_be = 4'b1111; data passes through unchanged.
  - Loads also drive dm_be per size.
- resp_ext_sel = {size==half, unsigned}. resp_is_word = load && size is word.
- Stores: resp_rdata = 0 and resp_ext_sel = 0.
- Boundary cases:
  - dm_ack outside WAIT is ignored.
  - dm_ack in the same cycle the counter hits the limit: ack wins, resp_err = 0.
  - req_valid while not IDLE is ignored; the requester holds the request.
- Timeout: resp_err = 1, resp_rdata = 0, no retry.

Optional Feature:
- Macro LSU_MISALIGN_EXC_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, skips WAIT. IDLE goes directly to RESP, dm_req is never asserted, and resp_err = 1.
- Not defined: no misalignment check. Half accesses ignore addr[0]; word accesses ignore addr[1:0]; the access proceeds normally.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - extension codes EXT_LB/EXT_LBU/EXT_LH/EXT_LHU (0..3);
  - state enum IDLE/WAIT/RESP.
- Sub-module lsu_lane_align (combinational): produces be/wdata from size/off/wdata, and the aligned read from size/off/rdata. The FSM and counter stay in the top module.

Test Plan:
- sb addr 0x1003, wdata 0x000000A5, ack after 1 cycle -> dm_addr 0x1000, dm_be 1000, dm_wdata 0xA5A5A5A5, dm_we 1, resp_valid at cycle 2, resp_err 0.
- lbu addr 0x2002, dm_rdata 0x11F2_3344, ack after 3 WAIT cycles -> resp_rdata 0x000000F2, resp_ext_sel 1, resp_valid at cycle 4.
- lh addr 0x3002, dm_rdata 0x8001_7FFF -> resp_rdata 0x00008001, resp_ext_sel 2, resp_is_word 0. lw same address with 0x3000 -> resp_rdata 0x80017FFF, resp_is_word 1.
- No dm_ack with TIMEOUT = 4 -> dm_req high for 4 cycles, then resp_valid with resp_err 1 and resp_rdata 0. Second case: ack on the 4th cycle -> resp_err 0.
- rst_n low during WAIT -> dm_req 0 and req_ready 1 in the same cycle; no resp_valid after release; next request completes normally.
- With LSU_MISALIGN_EXC_EN, lw addr 0x0002 -> dm_req never asserted, resp_valid at cycle 1 with resp_err 1. Without the macro -> access to 0x0000 with dm_be 1111.
